// File: rtl/dffram_1w1r_param_if.sv
// Port bundle for the 1W1R flop RAM: write port, read port and
// the clear-sequencer request/status pair.
interface dffram_1w1r_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic                INIT;
    logic                BUSY;
    logic                EN0;
    logic [DATA_W/8-1:0] WE0;
    logic [ADDR_W-1:0]   A0;
    logic [DATA_W-1:0]   Di0;
    logic                EN1;
    logic [ADDR_W-1:0]   A1;
    logic [DATA_W-1:0]   Do1;
    logic                Do1_VALID;

    modport master (
        output INIT, EN0, WE0, A0, Di0, EN1, A1,
        input  BUSY, Do1, Do1_VALID
    );

    modport slave (
        input  INIT, EN0, WE0, A0, Di0, EN1, A1,
        output BUSY, Do1, Do1_VALID
    );
endinterface

// File: rtl/dffram_1w1r_param.sv
// Byte-masked 1W1R flop RAM with 1/2-cycle read latency,
// optional write-to-read bypass and a zeroing sequencer.
module dffram_1w1r_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 1,
    parameter int BYPASS   = 1
) (
    input  logic CLK,
    input  logic RST_N,
    dffram_1w1r_param_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    if (DATA_W % 8 != 0 || !(READ_LAT == 1 || READ_LAT == 2))
    begin : g_bad_cfg
        $error("dffram_1w1r_param: illegal DATA_W or READ_LAT");
    end

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              busy;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] rd_data;
    logic              hit;
    logic              rd_ok;

    logic [DATA_W-1:0] d1;
    logic              v1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            unique case (state)
                CLEAR: begin
                    cnt <= cnt + ADDR_W'(1);
                    if (cnt == '1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (bus.INIT) begin
                        cnt   <= '0;
                        state <= CLEAR;
                        busy  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // The array has no reset; the sequencer owns the write port while busy.
    always_ff @(posedge CLK) begin
        if (busy) begin
            mem[cnt] <= '0;
        end else if (bus.EN0) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.WE0[i]) begin
                    mem[bus.A0][8*i +: 8] <= bus.Di0[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        hit     = (BYPASS != 0) && bus.EN0 && (bus.A0 == bus.A1);
        rd_data = mem[bus.A1];
        for (int i = 0; i < NB; i++) begin
            if (hit && bus.WE0[i]) begin
                rd_data[8*i +: 8] = bus.Di0[8*i +: 8];
            end
        end
        rd_ok = !busy && bus.EN1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            d1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= rd_ok;
            d1 <= rd_ok ? rd_data : '0;
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] d2;
        logic              v2;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                d2 <= '0;
                v2 <= 1'b0;
            end else begin
                d2 <= d1;
                v2 <= v1;
            end
        end

        assign bus.Do1       = d2;
        assign bus.Do1_VALID = v2;
    end else begin : g_lat1
        assign bus.Do1       = d1;
        assign bus.Do1_VALID = v1;
    end

    assign bus.BUSY = busy;
endmodule

// File: tb/tb_dffram_1w1r_param.sv
// Directed bench: DUT a is READ_LAT=1/BYPASS=1, DUT b is
// READ_LAT=2/BYPASS=0; both see identical stimulus.
module tb_dffram_1w1r_param;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init = 1'b0;
    logic        en0 = 1'b0;
    logic [3:0]  we0 = 4'h0;
    logic [7:0]  a0 = 8'h0;
    logic [31:0] di0 = 32'h0;
    logic        en1 = 1'b0;
    logic [7:0]  a1 = 8'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dffram_1w1r_param_if #(.DATA_W(32), .ADDR_W(8)) if_a ();
    dffram_1w1r_param_if #(.DATA_W(32), .ADDR_W(8)) if_b ();

    assign if_a.INIT = init;
    assign if_a.EN0  = en0;
    assign if_a.WE0  = we0;
    assign if_a.A0   = a0;
    assign if_a.Di0  = di0;
    assign if_a.EN1  = en1;
    assign if_a.A1   = a1;
    assign if_b.INIT = init;
    assign if_b.EN0  = en0;
    assign if_b.WE0  = we0;
    assign if_b.A0   = a0;
    assign if_b.Di0  = di0;
    assign if_b.EN1  = en1;
    assign if_b.A1   = a1;

    dffram_1w1r_param #(
        .DATA_W(32), .ADDR_W(8), .READ_LAT(1), .BYPASS(1)
    ) u_a (
        .CLK(clk), .RST_N(rst_n), .bus(if_a)
    );

    dffram_1w1r_param #(
        .DATA_W(32), .ADDR_W(8), .READ_LAT(2), .BYPASS(0)
    ) u_b (
        .CLK(clk), .RST_N(rst_n), .bus(if_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] we);
        en0 = 1'b1;
        a0  = a;
        di0 = d;
        we0 = we;
        step();
        en0 = 1'b0;
        we0 = 4'h0;
    endtask

    // Any write set up by the caller rides along with the read cycle.
    task automatic rd(input logic [7:0] a, input logic [31:0] ea,
                      input logic [31:0] eb, input string tag);
        en1 = 1'b1;
        a1  = a;
        step();
        en1 = 1'b0;
        en0 = 1'b0;
        we0 = 4'h0;
        chk({tag, "_a_data"}, if_a.Do1, ea);
        chk({tag, "_a_vld"}, 32'(if_a.Do1_VALID), 32'd1);
        chk({tag, "_b_early"}, 32'(if_b.Do1_VALID), 32'd0);
        step();
        chk({tag, "_b_data"}, if_b.Do1, eb);
        chk({tag, "_b_vld"}, 32'(if_b.Do1_VALID), 32'd1);
        chk({tag, "_a_drop"}, 32'(if_a.Do1_VALID), 32'd0);
    endtask

    task automatic chk_idle_out(input string tag);
        chk({tag, "_a_busy"}, 32'(if_a.BUSY), 32'd1);
        chk({tag, "_b_busy"}, 32'(if_b.BUSY), 32'd1);
        chk({tag, "_a_do"}, if_a.Do1, 32'h0);
        chk({tag, "_b_do"}, if_b.Do1, 32'h0);
        chk({tag, "_a_vld"}, 32'(if_a.Do1_VALID), 32'd0);
        chk({tag, "_b_vld"}, 32'(if_b.Do1_VALID), 32'd0);
    endtask

    task automatic wait_clear(input string tag);
        int fa = 0;
        int fb = 0;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (fa == 0 && !if_a.BUSY) fa = k;
            if (fb == 0 && !if_b.BUSY) fb = k;
        end
        chk({tag, "_a_len"}, 32'(fa), 32'd256);
        chk({tag, "_b_len"}, 32'(fb), 32'd256);
    endtask

    initial begin
        int ha;
        int hb;
        int fa;
        int fb;

        // Reset and power-up clear
        en1 = 1'b1;
        a1  = 8'h05;
        repeat (3) step();
        chk_idle_out("reset");
        en1 = 1'b0;
        rst_n = 1'b1;
        wait_clear("pwr_clear");

        rd(8'd0,   32'h0, 32'h0, "zero0");
        rd(8'd127, 32'h0, 32'h0, "zero127");
        rd(8'd255, 32'h0, 32'h0, "zero255");

        // Byte masking
        wr(8'h10, 32'hAABBCCDD, 4'b1111);
        wr(8'h10, 32'h11223344, 4'b0101);
        rd(8'h10, 32'hAA22CC44, 32'hAA22CC44, "bytemask");

        wr(8'h11, 32'hCAFEF00D, 4'b0000);
        rd(8'h11, 32'h0, 32'h0, "we_zero");

        // Collision: a bypasses, b returns the old word
        wr(8'h20, 32'h12345678, 4'b1111);
        en0 = 1'b1;
        a0  = 8'h20;
        di0 = 32'hFFFFFFFF;
        we0 = 4'b0011;
        rd(8'h20, 32'h1234FFFF, 32'h12345678, "collide");
        rd(8'h20, 32'h1234FFFF, 32'h1234FFFF, "after_collide");

        // Back-to-back reads
        wr(8'h01, 32'd1, 4'hF);
        wr(8'h02, 32'd2, 4'hF);
        wr(8'h03, 32'd3, 4'hF);
        en1 = 1'b1;
        a1  = 8'h01;
        step();
        a1 = 8'h02;
        chk("b2b_a0", if_a.Do1, 32'd1);
        chk("b2b_b0_vld", 32'(if_b.Do1_VALID), 32'd0);
        step();
        a1 = 8'h03;
        chk("b2b_a1", if_a.Do1, 32'd2);
        chk("b2b_b1", if_b.Do1, 32'd1);
        chk("b2b_b1_vld", 32'(if_b.Do1_VALID), 32'd1);
        step();
        en1 = 1'b0;
        chk("b2b_a2", if_a.Do1, 32'd3);
        chk("b2b_b2", if_b.Do1, 32'd2);
        chk("b2b_b2_vld", 32'(if_b.Do1_VALID), 32'd1);
        step();
        chk("b2b_a3_vld", 32'(if_a.Do1_VALID), 32'd0);
        chk("b2b_b3", if_b.Do1, 32'd3);
        chk("b2b_b3_vld", 32'(if_b.Do1_VALID), 32'd1);
        step();
        chk("b2b_b4_vld", 32'(if_b.Do1_VALID), 32'd0);
        chk("b2b_b4_do", if_b.Do1, 32'd0);

        // INIT with blocked access and an ignored second INIT
        wr(8'h30, 32'hDEADBEEF, 4'hF);
        rd(8'h30, 32'hDEADBEEF, 32'hDEADBEEF, "preinit");
        init = 1'b1;
        ha = 0;
        hb = 0;
        fa = 0;
        fb = 0;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (if_a.BUSY) ha++;
            if (if_b.BUSY) hb++;
            if (fa == 0 && !if_a.BUSY) fa = k;
            if (fb == 0 && !if_b.BUSY) fb = k;
            if (k == 1) begin
                init = 1'b0;
                en0  = 1'b1;
                we0  = 4'hF;
                a0   = 8'h40;
                di0  = 32'h5;
                en1  = 1'b1;
                a1   = 8'h30;
            end else if (k == 2) begin
                en0 = 1'b0;
                we0 = 4'h0;
                en1 = 1'b0;
                init = 1'b1;
                chk("busy_rd_a_do", if_a.Do1, 32'h0);
                chk("busy_rd_a_vld", 32'(if_a.Do1_VALID), 32'd0);
            end else if (k == 3) begin
                init = 1'b0;
                chk("busy_rd_b_do", if_b.Do1, 32'h0);
                chk("busy_rd_b_vld", 32'(if_b.Do1_VALID), 32'd0);
            end
        end
        chk("init_a_high", 32'(ha), 32'd256);
        chk("init_b_high", 32'(hb), 32'd256);
        chk("init_a_fall", 32'(fa), 32'd257);
        chk("init_b_fall", 32'(fb), 32'd257);
        rd(8'h30, 32'h0, 32'h0, "init_30");
        rd(8'h40, 32'h0, 32'h0, "init_40");

        // Reset in the middle of a clear
        wr(8'h70, 32'h0BADF00D, 4'hF);
        init = 1'b1;
        step();
        init = 1'b0;
        repeat (99) step();
        rst_n = 1'b0;
        en1 = 1'b1;
        a1  = 8'h70;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk_idle_out($sformatf("midrst%0d", k));
            step();
        end
        en1 = 1'b0;
        rst_n = 1'b1;
        wait_clear("midrst_clear");
        rd(8'h70, 32'h0, 32'h0, "midrst_70");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/dffram_1w1r_param.md
Name: dffram_1w1r_param

Overview:
- Parametrised successor of the 256x32 single-port flop RAM used by the neuron core.
- One byte-masked write port and one independent read port, plus:
  - configurable read latency,
  - selectable read-during-write bypass,
  - a built-in clear sequencer that zeroes the array after reset or on request.
- Used for the weight and membrane-potential stores, where a deterministic zero state is required without host writes.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- READ_LAT, 1, read latency in cycles; legal values 1 or 2.
- BYPASS, 1, 1 = read returns newly written data on same-address collision; 0 = read returns old data.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- INIT  input  1  single-cycle request to re-clear the whole array; honoured only when BUSY=0.
- BUSY  output  1  high while the clear sequencer owns the array.
- EN0  input  1  write-port enable.
- WE0  input  DATA_W/8  per-byte write enables; bit i covers Di0[8i+7:8i].
- A0  input  ADDR_W  write address.
- Di0  input  DATA_W  write data.
- EN1  input  1  read-port enable.
- A1  input  ADDR_W  read address.
- Do1  output  DATA_W  read data.
- Do1_VALID  output  1  high in the cycle Do1 carries data from an accepted read.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - BUSY=1, Do1=0, Do1_VALID=0, all pipeline stages cleared, clear counter=0, FSM=CLEAR.
  - The array itself has no reset; it is zeroed by the sequencer.
- FSM states: CLEAR, IDLE.
  - CLEAR: one word per cycle is written to all-zero at counter address; counter increments.
  - When counter = DEPTH-1 has been written: next state IDLE, BUSY=0 from the following cycle.
  - A full clear takes exactly DEPTH cycles after RST_N deasserts.
  - IDLE + INIT=1: counter<=0, next state CLEAR, BUSY=1 next cycle.
  - INIT while BUSY=1 is ignored; the clear is not restarted.
  - RST_N asserted mid-clear: counter returns to 0 and the clear restarts from word 0 after release.
- While BUSY=1:
  - Writes are dropped.
  - Reads are not accepted: Do1_VALID=0 and Do1=0 at the output stage.
- Write (BUSY=0, EN0=1):
  - Bytes with WE0[i]=1 are updated at the edge; other bytes are unchanged.
  - EN0=1 with WE0=0 is a no-op.
- Read (BUSY=0, EN1=1):
  - RAM[A1] is sampled at the edge.
  - READ_LAT=1: Do1/Do1_VALID are valid after 1 edge.
  - READ_LAT=2: one extra output register stage; valid after 2 edges.
  - Fully pipelined: one read per cycle at either latency.
- EN1=0 (or BUSY=1): the pipeline stage loads Do1=0 and Do1_VALID=0.
  - Matches the legacy convention that a disabled read yields zero.
- Collision (EN0=1, EN1=1, A0==A1, same cycle):
  - BYPASS=1: read data = byte-merge of Di0 (bytes with WE0 set) and old word (others).
  - BYPASS=0: read data = old word.
  - The write always completes.
- Address wrap: addresses are ADDR_W wide; no out-of-range case exists.
- Width rule: DATA_W%8 != 0 or READ_LAT not in {1,2} is a configuration error, flagged by an elaboration-time check.

Test Plan:
- Reset/clear:
  - Release RST_N, count cycles until BUSY falls -> exactly 256 (default params).
  - Then read addresses 0, 127, 255 -> Do1=0x00000000, Do1_VALID=1 after READ_LAT.
- Byte masking:
  - Write A0=0x10, Di0=0xAABBCCDD, WE0=4'b1111.
  - Then write Di0=0x11223344, WE0=4'b0101.
  - Read 0x10 -> 0xAA22CC44.
- Collision:
  - Word 0x20 holds 0x12345678.
  - Same cycle: write Di0=0xFFFFFFFF, WE0=4'b0011 and read A1=0x20.
  - BYPASS=1 -> Do1=0x1234FFFF; BYPASS=0 -> 0x12345678.
  - Next read returns 0x1234FFFF in both cases.
- Latency/throughput with READ_LAT=2:
  - Back-to-back reads of 0x01, 0x02, 0x03 (preloaded 1, 2, 3).
  - Do1 = 1, 2, 3 on consecutive cycles starting 2 edges after the first request.
  - Do1_VALID high for exactly 3 cycles.
- INIT and blocking:
  - Load 0x30 = 0xDEADBEEF, pulse INIT.
  - During BUSY: write 0x40 = 0x5 and read 0x30 -> Do1_VALID=0, Do1=0.
  - A second INIT pulse during BUSY is ignored: BUSY lasts exactly 256 cycles from the first INIT.
  - After BUSY falls: 0x30 and 0x40 read 0.
- Reset mid-clear:
  - Assert RST_N=0 at clear cycle 100 for 3 cycles.
  - BUSY stays 1; after release BUSY falls exactly 256 cycles later.
  - Do1 and Do1_VALID are 0 throughout reset.
